dma_block_writer: RTL

Cycle-stealing DMA engine that sits directly upstream of the data-side port of the 4-word-line memory. It accepts a transfer command from the CPU and pulls 64-bit lines (4 x 16-bit words) from an external device. It writes each line into memory, requesting the bus per line and releasing it between lines so the CPU regains the bus. It pulses an interrupt on completion.

---
 rtl/dma_pkg.sv | 26 ++
 rtl/dma_line_buffer.sv | 89 ++++++++
 rtl/dma_block_writer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dma_pkg
// Purpose  : Shared types and default sizes for the cycle-stealing DMA block
//            writer (state encoding, line geometry, write occupancy).
// Revision : 1.0 - initial release
// ============================================================================
package dma_pkg;

  localparam int WORD_SIZE     = 16;
  localparam int LINE_WORDS    = 4;
  localparam int LINE_BITS     = 64;
  localparam int WRITE_LATENCY = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    REQ       = 3'd2,
    WRITE     = 3'd3,
    RELEASE   = 3'd4,
    DONE      = 3'd5
  } dma_state_e;

endpackage
`default_nettype wire

// File: rtl/dma_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dma_line_buffer
// Purpose  : 1- or 2-entry FIFO holding device lines until they are written
//            to memory. Head entry is presented on head_data_o.
// Revision : 1.0 - initial release
// ============================================================================
module dma_line_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             valid_o,
  output logic             full_o
);

  if (DEPTH == 1) begin : g_single
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // Single slot: a push always overwrites, a pop alone empties it.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (flush_i) begin
        valid_q <= 1'b0;
      end else if (push_i) begin
        data_q  <= push_data_i;
        valid_q <= 1'b1;
      end else if (pop_i) begin
        valid_q <= 1'b0;
      end
    end

    assign head_data_o = data_q;
    assign valid_o     = valid_q;
    assign full_o      = valid_q;
  end else begin : g_double
    logic [WIDTH-1:0] e0_q;
    logic [WIDTH-1:0] e1_q;
    logic [1:0]       cnt_q;

    // Two-slot shift FIFO: e0 is always the head; pops shift e1 down.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        e0_q  <= '0;
        e1_q  <= '0;
        cnt_q <= 2'd0;
      end else if (flush_i) begin
        cnt_q <= 2'd0;
      end else begin
        case ({push_i, pop_i})
          2'b10: begin
            if (cnt_q == 2'd0) e0_q <= push_data_i;
            else               e1_q <= push_data_i;
            cnt_q <= cnt_q + 2'd1;
          end
          2'b01: begin
            e0_q  <= e1_q;
            cnt_q <= cnt_q - 2'd1;
          end
          2'b11: begin
            if (cnt_q == 2'd1) begin
              e0_q <= push_data_i;
            end else begin
              e0_q <= e1_q;
              e1_q <= push_data_i;
            end
          end
          default: ;
        endcase
      end
    end

    assign head_data_o = e0_q;
    assign valid_o     = (cnt_q != 2'd0);
    assign full_o      = (cnt_q == 2'd2);
  end

endmodule
`default_nettype wire

// File: rtl/dma_block_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dma_block_writer
// Purpose  : Cycle-stealing DMA engine. Pulls lines from a device, requests
//            the bus once per line, writes the line to memory for
//            WRITE_LATENCY cycles, releases the bus for one cycle between
//            lines and pulses dma_done at the end of the command.
//            Build option DMA_PREFETCH_EN: 2-entry buffer, device lines are
//            fetched during REQ/WRITE/RELEASE.
// Revision : 1.0 - initial release
// ============================================================================
module dma_block_writer #(
  parameter int WORD_SIZE     = dma_pkg::WORD_SIZE,
  parameter int LINE_WORDS    = dma_pkg::LINE_WORDS,
  parameter int WRITE_LATENCY = dma_pkg::WRITE_LATENCY
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [WORD_SIZE-1:0]              cmd_addr,
  input  logic [WORD_SIZE-1:0]              cmd_length,
  input  logic                              dev_valid,
  output logic                              dev_ready,
  input  logic [LINE_WORDS*WORD_SIZE-1:0]   dev_data,
  output logic                              bus_request,
  input  logic                              bus_grant,
  output logic [WORD_SIZE-1:0]              mem_address,
  output logic                              mem_write,
  inout  wire  [LINE_WORDS*WORD_SIZE-1:0]   mem_data,
  output logic                              dma_done
);
  import dma_pkg::*;

  localparam int LINE_W = LINE_WORDS * WORD_SIZE;
  localparam int LAT_W  = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(WRITE_LATENCY - 1);
`ifdef DMA_PREFETCH_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif

  dma_state_e           state_q, state_d;
  logic [WORD_SIZE-1:0] base_q, base_d;
  logic [WORD_SIZE-1:0] offset_q, offset_d;
  logic [WORD_SIZE-1:0] remain_q, remain_d;
  logic [WORD_SIZE-1:0] fetch_left_q, fetch_left_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic                 grant_q;

  logic                 push;
  logic                 pop;
  logic                 flush;
  logic [LINE_W-1:0]    buf_data;
  logic                 buf_valid;
  logic                 buf_full;
  logic [WORD_SIZE:0]   len_round;
  logic [WORD_SIZE-1:0] cmd_lines;

  // Line count is ceil(length / LINE_WORDS), computed one bit wider to
  // survive lengths near the top of the range.
  assign len_round = {1'b0, cmd_length} + (WORD_SIZE+1)'(LINE_WORDS - 1);
  assign cmd_lines = WORD_SIZE'(len_round / (WORD_SIZE+1)'(LINE_WORDS));

`ifdef DMA_PREFETCH_EN
  assign dev_ready = (state_q != IDLE) && (state_q != DONE) && !buf_full &&
                     (fetch_left_q != '0);
`else
  assign dev_ready = (state_q == WAIT_DATA) && !buf_full && (fetch_left_q != '0);
`endif
  assign push = dev_ready && dev_valid;

  dma_line_buffer #(
    .WIDTH (LINE_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (dev_data),
    .pop_i       (pop),
    .head_data_o (buf_data),
    .valid_o     (buf_valid),
    .full_o      (buf_full)
  );

  // The memory data bus is only driven while a write is actually enabled.
  assign mem_data    = mem_write ? buf_data : {LINE_W{1'bz}};
  assign mem_address = mem_write ? (base_q + offset_q) : '0;

  // State and datapath registers; bus_grant is also registered for REQ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      offset_q     <= '0;
      remain_q     <= '0;
      fetch_left_q <= '0;
      lat_q        <= '0;
      grant_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      offset_q     <= offset_d;
      remain_q     <= remain_d;
      fetch_left_q <= fetch_left_d;
      lat_q        <= lat_d;
      grant_q      <= bus_grant;
    end
  end

  // Next-state and output decode; losing the grant mid-write aborts the
  // line back to REQ with the occupancy count restarted.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    offset_d     = offset_q;
    remain_d     = remain_q;
    fetch_left_d = push ? (fetch_left_q - WORD_SIZE'(1)) : fetch_left_q;
    lat_d        = lat_q;
    cmd_ready    = 1'b0;
    bus_request  = 1'b0;
    mem_write    = 1'b0;
    dma_done     = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_length == '0) begin
            state_d = DONE;
          end else begin
            base_d       = cmd_addr & ~WORD_SIZE'(LINE_WORDS - 1);
            offset_d     = '0;
            remain_d     = cmd_lines;
            fetch_left_d = cmd_lines;
            state_d      = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (push || buf_valid) state_d = REQ;
      end
      REQ: begin
        bus_request = 1'b1;
        lat_d       = '0;
        if (grant_q && bus_grant) state_d = WRITE;
      end
      WRITE: begin
        bus_request = 1'b1;
        if (!bus_grant) begin
          lat_d   = '0;
          state_d = REQ;
        end else begin
          mem_write = 1'b1;
          if (lat_q == LAT_LAST) begin
            pop      = 1'b1;
            lat_d    = '0;
            offset_d = offset_q + WORD_SIZE'(LINE_WORDS);
            remain_d = remain_q - WORD_SIZE'(1);
            state_d  = (remain_q == WORD_SIZE'(1)) ? DONE : RELEASE;
          end else begin
            lat_d = lat_q + LAT_W'(1);
          end
        end
      end
      RELEASE: begin
        state_d = buf_valid ? REQ : WAIT_DATA;
      end
      DONE: begin
        dma_done = 1'b1;
        flush    = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire
